// File: rtl/mem_bank_responder_pkg.sv
// rtl/mem_bank_responder_pkg.sv - shared types and constants for the memory bank responder
package mem_bank_responder_pkg;

    localparam int MEM_ROWS = 512;
    localparam int MEM_W    = 16;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } data_width_t;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        RETENTION = 2'd1,
        WAKE      = 2'd2
    } bank_pwr_state_t;

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - behavioural single-width SRAM bank, one write port and one registered read port
module mem_bank #(
    parameter int ROWS = 512,
    parameter int W    = 16,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [RW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [ROWS];

    // Contents are never reset; a same-row read returns the old word (caller forwards).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_bank_responder.sv
// rtl/mem_bank_responder.sv - two-bank memory responder with 2-cycle reads, forwarding and retention FSM
module mem_bank_responder
    import mem_bank_responder_pkg::*;
#(
    parameter int N_ROWS      = MEM_ROWS,
    parameter int W           = MEM_W,
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 4,
    parameter int AW          = $clog2(N_ROWS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  data_width_t   rd_data_width,
    output logic [2*W-1:0] rd_data,
    input  logic          wr_en,
    input  logic          wr_chip_en,
    input  logic [2*W-1:0] wr_data,
    input  logic [AW-1:0] wr_addr,
    input  data_width_t   wr_data_width,
    output logic          rd_valid,
    output logic          busy,
    output logic          err_misalign,
    output logic          err_dropped,
    input  logic          clr_err
);

    localparam int RW = AW - 1;
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int KW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES);
    localparam logic [KW-1:0] WAKE_LAST = KW'(WAKE_CYCLES - 1);

    bank_pwr_state_t state, state_nxt;
    logic [IW-1:0]   idle_cnt, idle_cnt_nxt;
    logic [KW-1:0]   wake_cnt, wake_cnt_nxt;

    logic          rd_dbl, wr_dbl, rd_go, wr_go, activity;
    logic [RW-1:0] rd_row, wr_row;
    logic          we0, we1;
    logic [W-1:0]  wd0, wd1, dout0, dout1;

    logic          s1_valid, s1_dbl, s1_bank, s1_fwd0, s1_fwd1;
    logic [W-1:0]  s1_fd0, s1_fd1;
    logic [W-1:0]  b0, b1, bsel;
    logic [2*W-1:0] rd_result;
    logic          mis_set, drop_set;

    assign busy     = (state != ACTIVE);
    assign rd_dbl   = (rd_data_width == DOUBLE_WIDTH);
    assign wr_dbl   = (wr_data_width == DOUBLE_WIDTH);
    assign rd_go    = rd_en && !busy;
    assign wr_go    = wr_en && wr_chip_en && !busy;
    assign activity = rd_en || wr_en || wr_chip_en;

    // Row is addr>>1 for both widths, so forcing bit 0 low on misaligned doubles is implicit.
    assign rd_row = rd_addr[AW-1:1];
    assign wr_row = wr_addr[AW-1:1];
    assign we0    = wr_go && (wr_dbl || !wr_addr[0]);
    assign we1    = wr_go && (wr_dbl || wr_addr[0]);
    assign wd0    = wr_data[W-1:0];
    assign wd1    = wr_dbl ? wr_data[2*W-1:W] : wr_data[W-1:0];

    mem_bank #(.ROWS(N_ROWS), .W(W), .RW(RW)) u_bank0 (
        .clk(clk), .we(we0), .waddr(wr_row), .wdata(wd0),
        .re(rd_go), .raddr(rd_row), .rdata(dout0)
    );

    mem_bank #(.ROWS(N_ROWS), .W(W), .RW(RW)) u_bank1 (
        .clk(clk), .we(we1), .waddr(wr_row), .wdata(wd1),
        .re(rd_go), .raddr(rd_row), .rdata(dout1)
    );

    always_comb begin
        b0   = s1_fwd0 ? s1_fd0 : dout0;
        b1   = s1_fwd1 ? s1_fd1 : dout1;
        bsel = s1_bank ? b1 : b0;
        if (s1_dbl) begin
            rd_result = {b1, b0};
        end else begin
            rd_result = {{W{bsel[W-1]}}, bsel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_dbl   <= 1'b0;
            s1_bank  <= 1'b0;
            s1_fwd0  <= 1'b0;
            s1_fwd1  <= 1'b0;
            s1_fd0   <= '0;
            s1_fd1   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_dbl  <= rd_dbl;
                s1_bank <= rd_addr[0];
                s1_fwd0 <= we0 && (wr_row == rd_row);
                s1_fwd1 <= we1 && (wr_row == rd_row);
                s1_fd0  <= wd0;
                s1_fd1  <= wd1;
            end
            rd_valid <= s1_valid;
            if (s1_valid) begin
                rd_data <= rd_result;
            end
        end
    end

    assign mis_set  = (rd_go && rd_dbl && rd_addr[0]) || (wr_go && wr_dbl && wr_addr[0]);
    assign drop_set = busy && (rd_en || wr_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_misalign <= 1'b0;
            err_dropped  <= 1'b0;
        end else begin
            err_misalign <= mis_set || (err_misalign && !clr_err);
            err_dropped  <= drop_set || (err_dropped && !clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            wake_cnt <= wake_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        wake_cnt_nxt = wake_cnt;
        unique case (state)
            ACTIVE: begin
                if (activity) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt    = RETENTION;
                    idle_cnt_nxt = '0;
                end else begin
                    idle_cnt_nxt = idle_cnt + IW'(1);
                end
            end
            RETENTION: begin
                if (activity) begin
                    state_nxt    = WAKE;
                    wake_cnt_nxt = '0;
                end
            end
            WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ACTIVE;
                end else begin
                    wake_cnt_nxt = wake_cnt + KW'(1);
                end
            end
            default: state_nxt = ACTIVE;
        endcase
    end

endmodule

// File: tb/tb_mem_bank_responder.sv
// tb/tb_mem_bank_responder.sv - directed bench for mem_bank_responder
module tb_mem_bank_responder;
    import mem_bank_responder_pkg::*;

    localparam int AW = 10;
    localparam data_width_t S = SINGLE_WIDTH;
    localparam data_width_t D = DOUBLE_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    data_width_t   rd_data_width;
    logic [31:0]   rd_data;
    logic          wr_en;
    logic          wr_chip_en;
    logic [31:0]   wr_data;
    logic [AW-1:0] wr_addr;
    data_width_t   wr_data_width;
    logic          rd_valid;
    logic          busy;
    logic          err_misalign;
    logic          err_dropped;
    logic          clr_err;

    int n_pass  = 0;
    int n_total = 0;

    mem_bank_responder dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_width(rd_data_width), .rd_data(rd_data),
        .wr_en(wr_en), .wr_chip_en(wr_chip_en), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_data_width(wr_data_width),
        .rd_valid(rd_valid), .busy(busy), .err_misalign(err_misalign),
        .err_dropped(err_dropped), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Expected outputs are those seen just after the edge that consumes the row's inputs;
    // rd_valid in row i therefore reflects the read issued in row i-1.
    typedef struct {
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        data_width_t   rd_dw;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        data_width_t   wr_dw;
        logic [31:0]   wr_data;
        logic          exp_valid;
        logic [31:0]   exp_data;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic re, input int ra, input data_width_t rdw,
                                input logic we, input int wa, input data_width_t wdw,
                                input logic [31:0] wd, input logic ev, input logic [31:0] ed);
        vec_t v;
        v.rd_en = re; v.rd_addr = AW'(ra); v.rd_dw = rdw;
        v.wr_en = we; v.wr_addr = AW'(wa); v.wr_dw = wdw; v.wr_data = wd;
        v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; rd_addr = '0; rd_data_width = S;
        wr_en = 1'b0; wr_chip_en = 1'b0; wr_data = '0; wr_addr = '0; wr_data_width = S;
        clr_err = 1'b0;
    endtask

    task automatic do_rd(input int a, input data_width_t dw);
        rd_en = 1'b1; rd_addr = AW'(a); rd_data_width = dw;
    endtask

    task automatic do_wr(input int a, input data_width_t dw, input logic [31:0] d);
        wr_en = 1'b1; wr_chip_en = 1'b1; wr_addr = AW'(a); wr_data_width = dw; wr_data = d;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    initial begin
        vecs[0]  = mk(0, 0, S, 1, 5, S, 32'h0000_8001, 0, 32'h0);
        vecs[1]  = mk(1, 5, S, 0, 0, S, 32'h0, 0, 32'h0);
        vecs[2]  = mk(0, 0, S, 0, 0, S, 32'h0, 1, 32'hFFFF_8001);
        vecs[3]  = mk(0, 0, S, 1, 6, D, 32'h1234_5678, 0, 32'h0);
        vecs[4]  = mk(1, 6, S, 0, 0, S, 32'h0, 0, 32'h0);
        vecs[5]  = mk(1, 7, S, 0, 0, S, 32'h0, 1, 32'h0000_5678);
        vecs[6]  = mk(1, 10, D, 1, 10, D, 32'hAAAA_5555, 1, 32'h0000_1234);
        vecs[7]  = mk(0, 0, S, 0, 0, S, 32'h0, 1, 32'hAAAA_5555);
        vecs[8]  = mk(1, 10, D, 0, 0, S, 32'h0, 0, 32'h0);
        vecs[9]  = mk(0, 0, S, 0, 0, S, 32'h0, 1, 32'hAAAA_5555);
        vecs[10] = mk(1, 10, D, 1, 11, S, 32'h0000_7ABC, 0, 32'h0);
        vecs[11] = mk(0, 0, S, 0, 0, S, 32'h0, 1, 32'h7ABC_5555);
        vecs[12] = mk(1, 5, S, 1, 4, S, 32'h0000_1234, 0, 32'h0);
        vecs[13] = mk(1, 4, D, 0, 0, S, 32'h0, 1, 32'hFFFF_8001);
        vecs[14] = mk(0, 0, S, 0, 0, S, 32'h0, 1, 32'h8001_1234);
        vecs[15] = mk(1, 4, S, 0, 0, S, 32'h0, 0, 32'h0);
        vecs[16] = mk(1, 7, S, 0, 0, S, 32'h0, 1, 32'h0000_1234);
        vecs[17] = mk(0, 0, S, 0, 0, S, 32'h0, 1, 32'h0000_1234);

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err_misalign", 32'(err_misalign), 32'h0);
        chk("reset_err_dropped", 32'(err_dropped), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr; rd_data_width = vecs[i].rd_dw;
            wr_en = vecs[i].wr_en; wr_chip_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
            wr_data_width = vecs[i].wr_dw; wr_data = vecs[i].wr_data;
            tick();
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
        end
        idle();
        chk("table_no_misalign", 32'(err_misalign), 32'h0);

        // Misaligned double write lands at rows of addr 2/3; set beats clear.
        do_wr(3, D, 32'hCAFE_F00D);
        tick();
        chk("misalign_set", 32'(err_misalign), 32'h1);
        idle(); do_rd(2, S);
        tick();
        do_rd(3, S);
        tick();
        chk("misalign_lo_valid", 32'(rd_valid), 32'h1);
        chk("misalign_lo_data", rd_data, 32'hFFFF_F00D);
        idle();
        tick();
        chk("misalign_hi_data", rd_data, 32'hFFFF_CAFE);
        do_rd(1, D); clr_err = 1'b1;
        tick();
        chk("misalign_set_wins", 32'(err_misalign), 32'h1);
        idle(); clr_err = 1'b1;
        tick();
        chk("misalign_cleared", 32'(err_misalign), 32'h0);
        idle();

        // Retention entry, dropped requests, wake timing and data retention.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) tick();
        chk("busy_before_idle_limit", 32'(busy), 32'h0);
        tick();
        chk("busy_in_retention", 32'(busy), 32'h1);
        do_rd(5, S);
        tick();
        chk("wake_trigger_dropped", 32'(err_dropped), 32'h1);
        chk("wake_busy", 32'(busy), 32'h1);
        idle(); do_wr(4, D, 32'hDEAD_BEEF);
        tick();
        chk("dropped_rd_no_valid", 32'(rd_valid), 32'h0);
        idle();
        tick();
        chk("dropped_rd_no_valid_late", 32'(rd_valid), 32'h0);
        tick();
        chk("wake_busy_t3", 32'(busy), 32'h1);
        tick();
        chk("wake_done_t4", 32'(busy), 32'h0);
        do_rd(5, S);
        tick();
        do_rd(4, S);
        tick();
        chk("retained_valid", 32'(rd_valid), 32'h1);
        chk("retained_addr5", rd_data, 32'hFFFF_8001);
        idle();
        tick();
        chk("dropped_write_ignored", rd_data, 32'h0000_1234);
        chk("err_dropped_sticky", 32'(err_dropped), 32'h1);
        clr_err = 1'b1;
        tick();
        chk("err_dropped_cleared", 32'(err_dropped), 32'h0);
        idle();

        // Reset one cycle after a read issue flushes the pipeline.
        do_rd(5, D);
        tick();
        chk("pre_reset_misalign", 32'(err_misalign), 32'h1);
        idle(); rst = 1'b1;
        tick();
        chk("flush_rd_valid", 32'(rd_valid), 32'h0);
        chk("flush_rd_data", rd_data, 32'h0);
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_err_misalign", 32'(err_misalign), 32'h0);
        chk("flush_err_dropped", 32'(err_dropped), 32'h0);
        rst = 1'b0;
        tick();
        chk("flush_rd_valid_after", 32'(rd_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bank_responder.md
# mem_bank_responder

Memory-side responder for the centralized accelerator's `MemoryAccessSignals` interface: it serves one read port (requester drives en/addr/data_width, responder drives data) and one write port (en/chip_en/data/addr/data_width) onto two single-width SRAM banks. It handles single- and double-width accesses, a fixed-latency read pipeline, and a retention (sleep) state machine with an explicit wake sequence. It sits between the compute/master FSMs and the physical bank macros.

## Interface
- `N_ROWS`, 512: rows per bank.
- `W`, 16: single-width word bits; double width = 2·W.
- `IDLE_CYCLES`, 64: consecutive idle cycles before entering retention.
- `WAKE_CYCLES`, 4: cycles from wake trigger to ACTIVE.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rd` MemoryAccessSignals.data_out: en, addr, data_width in; data (2·W) out.
- `wr` MemoryAccessSignals.data_in: en, chip_en, data (2·W), addr, data_width in.
- `rd_valid` out 1: `rd.data` holds the result of the read issued 2 cycles earlier.
- `busy` out 1: high in RETENTION or WAKE.
- `err_misalign` out 1: sticky; set by a double-width access with addr[0]=1.
- `err_dropped` out 1: sticky; set by a request with busy=1.
- `clr_err` in 1: clears both sticky flags.

## Operation
- Address map: single-width addr A → bank A[0], row A>>1. Double-width addr A → row A>>1 in both banks; bank0 = data[W-1:0], bank1 = data[2W-1:W]. Misaligned double-width accesses set err_misalign and use A with bit 0 forced to 0.
- Write: commits when wr.en && wr.chip_en && !busy. A single-width write uses wr.data[W-1:0] and touches only the selected bank.
- Read: a single-width result is sign-extended to 2·W; a double-width result is the concatenation {bank1, bank0}.
- Read/write collision (same cycle, same bank and row): the read returns the new write data (write-first forwarding). For a double-width read against a single-width write, forward per half.
- FSM states:
  - ACTIVE: the idle counter increments when rd.en, wr.en and wr.chip_en are all low, and clears otherwise. At IDLE_CYCLES the FSM moves to RETENTION.
  - RETENTION: any en or wr.chip_en high moves the FSM to WAKE.
  - WAKE: counts WAKE_CYCLES, then moves to ACTIVE.
  - In RETENTION and WAKE, requests are dropped: no write, no rd_valid, err_dropped set.
- A clr_err in the same cycle as a new error leaves the flag set (set wins).

## Timing
- Reset values: FSM=ACTIVE, idle counter=0, rd.data=0, rd_valid=0, busy=0, err_*=0.
- Read latency is 2 cycles: address and forward mux are registered in cycle 1, bank output is registered in cycle 2. rd_valid pulses in cycle 2.
- Throughput is 1 read plus 1 write per cycle.
- Write data is visible to a read issued in the same cycle (forwarding) and in any later cycle.
- Reset mid-read flushes the pipeline: rd_valid=0 on the next cycle.
- busy rises in the cycle after the idle counter hits IDLE_CYCLES. It falls exactly WAKE_CYCLES cycles after the wake trigger.
- Bank contents are not cleared by reset and are retained through RETENTION.

## Structure
- Shared `Defines` package holds:
  - `DataWidth_t` (SINGLE_WIDTH, DOUBLE_WIDTH);
  - new enum `BankPwrState_t` (ACTIVE, RETENTION, WAKE);
  - `MEM_ROWS`, `MEM_W` constants.
- Sub-module `mem_bank`: single-port-read, single-port-write behavioural SRAM with 1-cycle registered read. Instantiated twice.

## Test plan
- Single-width write 0x8001 to addr 5, then read addr 5 → rd_valid 2 cycles later, data 0xFFFF8001 (sign-extended).
- Double-width write 0x12345678 to addr 6, then single-width reads of addr 6 and addr 7 → 0x00005678 and 0x00001234.
- Same-cycle double-width write 0xAAAA5555 and read at addr 10 → read returns 0xAAAA5555.
- Double-width write to addr 3 → err_misalign=1, data lands at addr 2/3. clr_err → flag 0.
- 64 idle cycles → busy=1; rd.en pulse → err_dropped=1, no rd_valid; busy falls 4 cycles later; subsequent read returns the data written before retention.
- rst asserted one cycle after a read issue → rd_valid stays 0 and all outputs return to reset values.
